exec_stage_pipe: RTL

EXEC_STAGE_PIPE -- requirements
Module: exec_stage_pipe

---
 rtl/exec_pkg.sv | 50 +++++
 rtl/exec_mul_iter.sv | 57 +++++
 rtl/exec_stage_pipe.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared icode/status constants, ALU and condition encodings
package exec_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_XOR = 4'd3, ALU_OR = 4'd4,
    ALU_SHL = 4'd5, ALU_SHR = 4'd6, ALU_SAR = 4'd7, ALU_MUL = 4'd8
  } alu_op_e;

  typedef enum logic [3:0] {
    C_YES = 4'd0, C_LE = 4'd1, C_L = 4'd2, C_E = 4'd3, C_NE = 4'd4, C_GE = 4'd5, C_G = 4'd6
  } cond_e;

  // cc packs {OF,SF,ZF}
  function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
    logic of, sf, zf;
    {of, sf, zf} = cc;
    case (cond_e'(ifun))
      C_YES:   cond_eval = 1'b1;
      C_LE:    cond_eval = (sf ^ of) | zf;
      C_L:     cond_eval = sf ^ of;
      C_E:     cond_eval = zf;
      C_NE:    cond_eval = !zf;
      C_GE:    cond_eval = !(sf ^ of);
      C_G:     cond_eval = !(sf ^ of) && !zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_mul_iter.sv
// rtl/exec_mul_iter.sv - iterative shift-add multiplier, MUL_STEP bits per cycle
module exec_mul_iter
  import exec_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int ITERS = WIDTH / MUL_STEP;
  localparam int CW    = $clog2(ITERS + 1);

  logic             active_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mplier_q;

  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier_q[i]) acc_d = acc_d + (mcand_q << i);
    end
  end

  // done is raised during the final iteration so the product is usable on that same edge
  assign done    = active_q && (cnt_q == CW'(1));
  assign product = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= CW'(ITERS);
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
    end else if (active_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << MUL_STEP;
      mplier_q <= mplier_q >> MUL_STEP;
      cnt_q    <= cnt_q - CW'(1);
      if (done) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_stage_pipe.sv
// rtl/exec_stage_pipe.sv - Y86 execute stage with valid/ready handshake and iterative MUL
module exec_stage_pipe
  import exec_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_icode,
  input  logic [3:0]       in_ifun,
  input  logic [WIDTH-1:0] in_valA,
  input  logic [WIDTH-1:0] in_valB,
  input  logic [WIDTH-1:0] in_valC,
  input  logic [3:0]       in_dstE,
  input  logic [3:0]       in_dstM,
  input  logic [2:0]       in_stat,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_icode,
  output logic             out_cnd,
  output logic [WIDTH-1:0] out_valE,
  output logic [WIDTH-1:0] out_valA,
  output logic [3:0]       out_dstE,
  output logic [3:0]       out_dstM,
  output logic [2:0]       out_stat,
  output logic [2:0]       cc,
  output logic             busy
);

  localparam int               SHW    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] PLUS8  = WIDTH'(8);
  localparam logic [WIDTH-1:0] MINUS8 = ~PLUS8 + WIDTH'(1);

  typedef enum logic {S_IDLE, S_MUL} state_e;
  state_e state_q, state_d;

  logic [WIDTH-1:0] alu_a, alu_b, alu_r;
  alu_op_e          alu_op;
  logic             bad_fun, alu_of;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (in_icode)
      I_RRMOVQ, I_OPQ:              alu_a = in_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = in_valC;
      I_CALL, I_PUSHQ:              alu_a = MINUS8;
      I_RET, I_POPQ:                alu_a = PLUS8;
      default:                      alu_a = '0;
    endcase
    case (in_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = in_valB;
      default:                                                   alu_b = '0;
    endcase
    bad_fun = (in_icode == I_OPQ) && (in_ifun > 4'd8);
    alu_op  = ALU_ADD;
    if (in_icode == I_OPQ && !bad_fun) alu_op = alu_op_e'(in_ifun);
  end

  always_comb begin
    alu_r  = '0;
    alu_of = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_r  = alu_b + alu_a;
        alu_of = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_r[WIDTH-1] != alu_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_r  = alu_b - alu_a;
        alu_of = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_r[WIDTH-1] != alu_b[WIDTH-1]);
      end
      ALU_AND: alu_r = alu_b & alu_a;
      ALU_XOR: alu_r = alu_b ^ alu_a;
      ALU_OR:  alu_r = alu_b | alu_a;
      ALU_SHL: alu_r = alu_b << alu_a[SHW-1:0];
      ALU_SHR: alu_r = alu_b >> alu_a[SHW-1:0];
      ALU_SAR: alu_r = WIDTH'($signed(alu_b) >>> alu_a[SHW-1:0]);
      default: alu_r = '0;
    endcase
    if (bad_fun) alu_r = '0;
  end

  logic             is_mul_in, xfer, mul_start, mul_done, cap_mul, cap_ld, cap_cnd, cap_of;
  logic [WIDTH-1:0] mul_prod, cap_valE, cap_valA;
  logic [3:0]       cap_icode, cap_ifun, cap_dstE, cap_dstM;
  logic [2:0]       cap_stat, cc_q, cc_d;

  assign is_mul_in = (alu_op == ALU_MUL);
  assign in_ready  = (state_q == S_IDLE) && (!out_valid || out_ready);
  assign xfer      = in_valid && in_ready;
  assign mul_start = xfer && is_mul_in;
  assign busy      = (state_q == S_MUL);
  assign cap_mul   = (state_q == S_MUL) && mul_done;
  assign cap_ld    = cap_mul || (xfer && !is_mul_in);
  assign cc        = cc_q;

  exec_mul_iter #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (alu_a),
    .b       (alu_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // MUL record fields are parked here while the multiplier runs
  logic [WIDTH-1:0] hold_valA_q;
  logic [3:0]       hold_dstE_q, hold_dstM_q;
  logic [2:0]       hold_stat_q;

  always_comb begin
    if (cap_mul) begin
      cap_icode = I_OPQ;
      cap_ifun  = 4'(ALU_MUL);
      cap_valE  = mul_prod;
      cap_of    = 1'b0;
      cap_valA  = hold_valA_q;
      cap_dstE  = hold_dstE_q;
      cap_dstM  = hold_dstM_q;
      cap_stat  = hold_stat_q;
    end else begin
      cap_icode = in_icode;
      cap_ifun  = in_ifun;
      cap_valE  = alu_r;
      cap_of    = alu_of;
      cap_valA  = in_valA;
      cap_dstE  = in_dstE;
      cap_dstM  = in_dstM;
      cap_stat  = bad_fun ? SINS : in_stat;
    end
    cap_cnd = (cap_stat == SBUB) ? 1'b0 : cond_eval(cap_ifun, cc_q);
    if (cap_icode == I_RRMOVQ && !cap_cnd) cap_dstE = RNONE;
    cc_d = cc_q;
    if (cap_ld && cap_icode == I_OPQ && cap_stat == SAOK &&
        (m_stat == SAOK || m_stat == SBUB) && (W_stat == SAOK || W_stat == SBUB))
      cc_d = {cap_of, cap_valE[WIDTH-1], (cap_valE == '0)};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mul_start) state_d = S_MUL;
      S_MUL:   if (mul_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic             out_valid_q, out_cnd_q;
  logic [3:0]       out_icode_q, out_dstE_q, out_dstM_q;
  logic [WIDTH-1:0] out_valE_q, out_valA_q;
  logic [2:0]       out_stat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cc_q        <= 3'b001;
      hold_valA_q <= '0;
      hold_dstE_q <= RNONE;
      hold_dstM_q <= RNONE;
      hold_stat_q <= SBUB;
      out_valid_q <= 1'b0;
      out_cnd_q   <= 1'b0;
      out_icode_q <= I_NOP;
      out_valE_q  <= '0;
      out_valA_q  <= '0;
      out_dstE_q  <= RNONE;
      out_dstM_q  <= RNONE;
      out_stat_q  <= SBUB;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      if (mul_start) begin
        hold_valA_q <= in_valA;
        hold_dstE_q <= in_dstE;
        hold_dstM_q <= in_dstM;
        hold_stat_q <= in_stat;
      end
      if (cap_ld) begin
        out_valid_q <= 1'b1;
        out_cnd_q   <= cap_cnd;
        out_icode_q <= cap_icode;
        out_valE_q  <= cap_valE;
        out_valA_q  <= cap_valA;
        out_dstE_q  <= cap_dstE;
        out_dstM_q  <= cap_dstM;
        out_stat_q  <= cap_stat;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_cnd   = out_cnd_q;
  assign out_icode = out_icode_q;
  assign out_valE  = out_valE_q;
  assign out_valA  = out_valA_q;
  assign out_dstE  = out_dstE_q;
  assign out_dstM  = out_dstM_q;
  assign out_stat  = out_stat_q;

endmodule
